// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and constants for the 8N1 UART engine
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  // Bit-timer width: enough bits to hold CLKS_PER_BIT-1
  function automatic int timer_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_txrx_if.sv
// rtl/uart_txrx_if.sv - byte handshake and serial line bundle between the UART wrapper and engine
interface uart_txrx_if;
  import uart_pkg::*;

  logic                 rx_i;
  logic                 tx_o;
  logic                 transmit;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 received;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 recv_error;
  logic                 is_receiving;
  logic                 is_transmitting;

  modport master (
    output rx_i, transmit, tx_byte,
    input  tx_o, received, rx_byte, recv_error, is_receiving, is_transmitting
  );

  modport slave (
    input  rx_i, transmit, tx_byte,
    output tx_o, received, rx_byte, recv_error, is_receiving, is_transmitting
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter that ticks while enabled at zero
module uart_bit_timer #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load value of N gives a tick N+1 enabled cycles later
  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - 8N1 UART serializer/deserializer with independent TX and RX FSMs
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  uart_txrx_if.slave bus
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_txrx: CLKS_PER_BIT must be >= 4");
  end

  // ---------------------------------------------------------------- TX
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_tx_busy, w_tx_busy_nxt;
  logic                 w_tx_load, w_tx_tick, w_tx_en;

  assign w_tx_en = (r_tx_state != T_IDLE);

  uart_bit_timer #(.W(TW)) u_tx_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_tx_load),
    .i_load_val (BIT_LOAD),
    .i_en       (w_tx_en),
    .o_tick     (w_tx_tick)
  );

  // TX state and datapath registers; tx_o forced high asynchronously on reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_state <= T_IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
    end
  end

  // TX next state: start, 8 data bits LSB first, stop; each bit one full timer period
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_nxt       = r_tx;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_load      = 1'b0;
    unique case (r_tx_state)
      T_IDLE: begin
        if (bus.transmit) begin
          w_tx_shift_nxt = bus.tx_byte;
          w_tx_nxt       = 1'b0;
          w_tx_busy_nxt  = 1'b1;
          w_tx_load      = 1'b1;
          w_tx_state_nxt = T_START;
        end
      end
      T_START: begin
        if (w_tx_tick) begin
          w_tx_nxt       = r_tx_shift[0];
          w_tx_bit_nxt   = '0;
          w_tx_load      = 1'b1;
          w_tx_state_nxt = T_DATA;
        end
      end
      T_DATA: begin
        if (w_tx_tick) begin
          w_tx_load = 1'b1;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_nxt       = 1'b1;
            w_tx_state_nxt = T_STOP;
          end else begin
            w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
            w_tx_nxt       = r_tx_shift[1];
            w_tx_bit_nxt   = r_tx_bit + 1'b1;
          end
        end
      end
      T_STOP: begin
        if (w_tx_tick) begin
          w_tx_busy_nxt  = 1'b0;
          w_tx_state_nxt = T_IDLE;
        end
      end
      default: begin
        w_tx_state_nxt = T_IDLE;
      end
    endcase
  end

  assign bus.tx_o            = r_tx;
  assign bus.is_transmitting = r_tx_busy;

  // ---------------------------------------------------------------- RX
  logic                 r_rx_meta, r_rxs;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_rx_byte, w_rx_byte_nxt;
  logic                 r_received, w_received_nxt;
  logic                 r_recv_error, w_recv_error_nxt;
  logic                 r_rx_busy, w_rx_busy_nxt;
  logic                 w_rx_load, w_rx_tick, w_rx_en;
  logic [TW-1:0]        w_rx_load_val;

  assign w_rx_en = (r_rx_state == R_START) || (r_rx_state == R_DATA) ||
                   (r_rx_state == R_STOP);

  uart_bit_timer #(.W(TW)) u_rx_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .i_en       (w_rx_en),
    .o_tick     (w_rx_tick)
  );

  // Two-flop synchronizer for the asynchronous serial input; idles high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx_i;
      r_rxs     <= r_rx_meta;
    end
  end

  // RX state and datapath registers; a partial byte is simply dropped on reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_state   <= R_IDLE;
      r_rx_shift   <= '0;
      r_rx_bit     <= '0;
      r_rx_byte    <= '0;
      r_received   <= 1'b0;
      r_recv_error <= 1'b0;
      r_rx_busy    <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_rx_bit     <= w_rx_bit_nxt;
      r_rx_byte    <= w_rx_byte_nxt;
      r_received   <= w_received_nxt;
      r_recv_error <= w_recv_error_nxt;
      r_rx_busy    <= w_rx_busy_nxt;
    end
  end

  // RX next state: half-bit delay to the start-bit centre, then sample every bit centre
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_shift_nxt   = r_rx_shift;
    w_rx_bit_nxt     = r_rx_bit;
    w_rx_byte_nxt    = r_rx_byte;
    w_received_nxt   = 1'b0;
    w_recv_error_nxt = 1'b0;
    w_rx_busy_nxt    = r_rx_busy;
    w_rx_load        = 1'b0;
    w_rx_load_val    = BIT_LOAD;
    unique case (r_rx_state)
      R_IDLE: begin
        if (!r_rxs) begin
          w_rx_load      = 1'b1;
          w_rx_load_val  = HALF_LOAD;
          w_rx_busy_nxt  = 1'b1;
          w_rx_state_nxt = R_START;
        end
      end
      R_START: begin
        if (w_rx_tick) begin
          if (!r_rxs) begin
            w_rx_load      = 1'b1;
            w_rx_bit_nxt   = '0;
            w_rx_state_nxt = R_DATA;
          end else begin
            w_rx_busy_nxt  = 1'b0;
            w_rx_state_nxt = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nxt = {r_rxs, r_rx_shift[DATA_BITS-1:1]};
          w_rx_load      = 1'b1;
          if (r_rx_bit == LAST_BIT) begin
            w_rx_state_nxt = R_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 1'b1;
          end
        end
      end
      R_STOP: begin
        if (w_rx_tick) begin
          if (r_rxs) begin
            w_rx_byte_nxt  = r_rx_shift;
            w_received_nxt = 1'b1;
            w_rx_busy_nxt  = 1'b0;
            w_rx_state_nxt = R_IDLE;
          end else begin
            w_recv_error_nxt = 1'b1;
            w_rx_state_nxt   = R_BREAK;
          end
        end
      end
      R_BREAK: begin
        if (r_rxs) begin
          w_rx_busy_nxt  = 1'b0;
          w_rx_state_nxt = R_IDLE;
        end
      end
      default: begin
        w_rx_busy_nxt  = 1'b0;
        w_rx_state_nxt = R_IDLE;
      end
    endcase
  end

  assign bus.rx_byte      = r_rx_byte;
  assign bus.received     = r_received;
  assign bus.recv_error   = r_recv_error;
  assign bus.is_receiving = r_rx_busy;

endmodule
